// File: rtl/operand_fetch_stage_pkg.sv
// Shared types and constants for the stage-2 operand fetch block.
package fetch_pkg;

    // Sequencer states, in the order the instruction words are visited.
    typedef enum logic [2:0] {
        IDLE,
        OP,
        AW,
        AV,
        BW,
        BV,
        DW,
        DONE
    } state_t;

    // Bit of word0 that selects an immediate A operand.
    localparam int IMM_A_BIT = 0;

    // Offsets of the instruction words relative to the fetched PC.
    localparam int OFF_OP      = 0;
    localparam int OFF_A       = 1;
    localparam int OFF_B       = 2;
    localparam int OFF_DEST    = 3;
    localparam int INSTR_WORDS = 4;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Handshake and memory bus bundle for the operand fetch stage.
// The stage itself uses the slave view; the surrounding pipeline/memory uses master.
interface operand_fetch_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int OP_W   = 8
);
    // Stage 1 side
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_ready;
    logic              flush;

    // Memory read port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Stage 3 side
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   op_out;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [ADDR_W-1:0] dest_out;
    logic [ADDR_W-1:0] next_pc;

    modport master (
        output fetch_valid, fetch_pc, flush, mem_ack, mem_rdata, out_ready,
        input  fetch_ready, mem_req, mem_addr, out_valid,
               op_out, a_out, b_out, dest_out, next_pc
    );

    modport slave (
        input  fetch_valid, fetch_pc, flush, mem_ack, mem_rdata, out_ready,
        output fetch_ready, mem_req, mem_addr, out_valid,
               op_out, a_out, b_out, dest_out, next_pc
    );

endinterface

// File: rtl/operand_fetch_stage_regn.sv
// Generic enabled register, cleared by the asynchronous reset.
module regn #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled; otherwise hold.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Stage-2 operand fetch: reads opcode, A (immediate or indirect), B (indirect)
// and destination for the instruction at fetch_pc, then presents them to
// stage 3 under a valid/ready handshake.
module operand_fetch_stage
    import fetch_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int OP_W   = 8
) (
    input  logic                 CLK,
    input  logic                 reset,
    operand_fetch_stage_if.slave bus
);

    state_t            state_reg;
    state_t            state_next;

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] next_pc_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] dest_reg;
    logic [OP_W-1:0]   op_reg;
    logic              imm_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;

    logic              pc_en;
    logic              op_en;
    logic              ptr_en;
    logic              a_en;
    logic              b_en;
    logic              dest_en;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              fetch_ready;
    logic              out_valid;
    logic              ack_ok;

    // A read completes only if flush is not aborting the instruction this cycle.
    assign ack_ok = bus.mem_ack && !bus.flush;

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, read address mux, register enables and handshake outputs.
    always_comb begin
        state_next  = state_reg;
        mem_req     = 1'b0;
        mem_addr    = '0;
        fetch_ready = 1'b0;
        out_valid   = 1'b0;
        pc_en       = 1'b0;
        op_en       = 1'b0;
        ptr_en      = 1'b0;
        a_en        = 1'b0;
        b_en        = 1'b0;
        dest_en     = 1'b0;

        case (state_reg)
            IDLE: begin
                fetch_ready = !bus.flush;
                if (bus.fetch_valid && !bus.flush) begin
                    pc_en      = 1'b1;
                    state_next = OP;
                end
            end
            OP: begin
                mem_req  = 1'b1;
                mem_addr = pc_reg + ADDR_W'(OFF_OP);
                if (ack_ok) begin
                    op_en      = 1'b1;
                    state_next = AW;
                end
            end
            AW: begin
                mem_req  = 1'b1;
                mem_addr = pc_reg + ADDR_W'(OFF_A);
                if (ack_ok) begin
                    // Immediate A is the word itself; otherwise it points at A.
                    if (imm_reg) begin
                        a_en       = 1'b1;
                        state_next = BW;
                    end else begin
                        ptr_en     = 1'b1;
                        state_next = AV;
                    end
                end
            end
            AV: begin
                mem_req  = 1'b1;
                mem_addr = ptr_reg;
                if (ack_ok) begin
                    a_en       = 1'b1;
                    state_next = BW;
                end
            end
            BW: begin
                mem_req  = 1'b1;
                mem_addr = pc_reg + ADDR_W'(OFF_B);
                if (ack_ok) begin
                    ptr_en     = 1'b1;
                    state_next = BV;
                end
            end
            BV: begin
                mem_req  = 1'b1;
                mem_addr = ptr_reg;
                if (ack_ok) begin
                    b_en       = 1'b1;
                    state_next = DW;
                end
            end
            DW: begin
                mem_req  = 1'b1;
                mem_addr = pc_reg + ADDR_W'(OFF_DEST);
                if (ack_ok) begin
                    dest_en    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Flush abandons whatever is in flight; data registers keep their values.
        if (bus.flush) begin
            state_next = IDLE;
        end
    end

    // Field registers, each loaded from the accepted PC or the returning read word.
    regn #(.W(ADDR_W)) u_pc (
        .CLK(CLK), .reset(reset), .en(pc_en),
        .d(bus.fetch_pc), .q(pc_reg)
    );

    regn #(.W(ADDR_W)) u_next_pc (
        .CLK(CLK), .reset(reset), .en(pc_en),
        .d(bus.fetch_pc + ADDR_W'(INSTR_WORDS)), .q(next_pc_reg)
    );

    regn #(.W(OP_W)) u_op (
        .CLK(CLK), .reset(reset), .en(op_en),
        .d(bus.mem_rdata[DATA_W-1 -: OP_W]), .q(op_reg)
    );

    regn #(.W(1)) u_imm (
        .CLK(CLK), .reset(reset), .en(op_en),
        .d(bus.mem_rdata[IMM_A_BIT]), .q(imm_reg)
    );

    regn #(.W(ADDR_W)) u_ptr (
        .CLK(CLK), .reset(reset), .en(ptr_en),
        .d(bus.mem_rdata[ADDR_W-1:0]), .q(ptr_reg)
    );

    regn #(.W(DATA_W)) u_a (
        .CLK(CLK), .reset(reset), .en(a_en),
        .d(bus.mem_rdata), .q(a_reg)
    );

    regn #(.W(DATA_W)) u_b (
        .CLK(CLK), .reset(reset), .en(b_en),
        .d(bus.mem_rdata), .q(b_reg)
    );

    regn #(.W(ADDR_W)) u_dest (
        .CLK(CLK), .reset(reset), .en(dest_en),
        .d(bus.mem_rdata[ADDR_W-1:0]), .q(dest_reg)
    );

    assign bus.fetch_ready = fetch_ready;
    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = mem_addr;
    assign bus.out_valid   = out_valid;
    assign bus.op_out      = op_reg;
    assign bus.a_out       = a_reg;
    assign bus.b_out       = b_reg;
    assign bus.dest_out    = dest_reg;
    assign bus.next_pc     = next_pc_reg;

endmodule
